// File: rtl/split_check_sequencer_pkg.sv
// Shared types and helpers for the split-check sequencer.
package split_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    CHECK = 2'd2,
    RESP  = 2'd3
  } state_t;

  // Index width for n items, never narrower than one bit.
  function automatic int sel_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/split_check_sequencer_sat_counter.sv
// Saturating event counter: counts inc pulses and sticks at all-ones.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  // Advance on inc unless already at the ceiling, so the count never wraps.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (inc && (count != {CNT_W{1'b1}})) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/split_check_sequencer.sv
// Drives one shared split checker over every split of a candidate and
// reduces the per-split results into a single SAT/UNSAT answer.
module split_check_sequencer
  import split_pkg::*;
#(
  parameter int VEC_W    = 400,
  parameter int N_SPLIT  = 4,
  parameter int EVAL_LAT = 1,
  parameter int TAG_W    = 8,
  parameter int CNT_W    = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        cand_valid,
  output logic                        cand_ready,
  input  logic [VEC_W-1:0]            cand_vec,
  input  logic [TAG_W-1:0]            cand_tag,
  output logic [sel_w(N_SPLIT)-1:0]   split_sel,
  output logic [VEC_W-1:0]            split_vec,
  input  logic                        split_x,
  output logic                        res_valid,
  input  logic                        res_ready,
  output logic                        res_sat,
  output logic [sel_w(N_SPLIT)-1:0]   res_fail_idx,
  output logic [TAG_W-1:0]            res_tag,
  output logic [CNT_W-1:0]            sat_cnt,
  output logic [CNT_W-1:0]            unsat_cnt
);

  localparam int SEL_W = sel_w(N_SPLIT);
  localparam int LAT_W = sel_w(EVAL_LAT);
  localparam logic [SEL_W-1:0] LAST_SEL  = SEL_W'(N_SPLIT - 1);
  localparam logic [LAT_W-1:0] WAIT_INIT = LAT_W'(EVAL_LAT - 1);

  state_t             state;
  state_t             state_next;
  logic [LAT_W-1:0]   wait_cnt;
  logic               accept;
  logic               res_hs;
  logic               last_split;
  logic               sat_inc;
  logic               unsat_inc;

  assign last_split = (split_sel == LAST_SEL);

  // Next-state and handshake decode; split_x only matters in CHECK.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    res_hs     = 1'b0;
    cand_ready = 1'b0;
    res_valid  = 1'b0;
    case (state)
      IDLE: begin
        cand_ready = 1'b1;
        accept     = cand_valid;
        if (cand_valid) state_next = WAIT;
      end
      WAIT: begin
        if (wait_cnt == '0) state_next = CHECK;
      end
      CHECK: begin
        if (!split_x || last_split) state_next = RESP;
        else                        state_next = WAIT;
      end
      RESP: begin
        res_valid = 1'b1;
        res_hs    = res_ready;
        if (res_ready) state_next = IDLE;
      end
    endcase
  end

  assign sat_inc   = res_hs & res_sat;
  assign unsat_inc = res_hs & ~res_sat;

  // State register plus the candidate/result datapath that follows it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      wait_cnt     <= '0;
      split_sel    <= '0;
      split_vec    <= '0;
      res_sat      <= 1'b0;
      res_fail_idx <= '0;
      res_tag      <= '0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (accept) begin
            split_vec <= cand_vec;
            res_tag   <= cand_tag;
            split_sel <= '0;
            wait_cnt  <= WAIT_INIT;
          end
        end
        WAIT: begin
          if (wait_cnt != '0) wait_cnt <= wait_cnt - LAT_W'(1);
        end
        CHECK: begin
          if (!split_x) begin
            res_sat      <= 1'b0;
            res_fail_idx <= split_sel;
          end else if (last_split) begin
            res_sat      <= 1'b1;
            res_fail_idx <= '0;
          end else begin
            split_sel <= split_sel + SEL_W'(1);
            wait_cnt  <= WAIT_INIT;
          end
        end
        RESP: begin
          if (res_ready) split_sel <= '0;
        end
      endcase
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_sat_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (sat_inc),
    .count (sat_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_unsat_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (unsat_inc),
    .count (unsat_cnt)
  );

endmodule

// File: tb/tb_split_check_sequencer.sv
// Scoreboard bench for split_check_sequencer: three instances cover the
// default configuration, a long-latency/narrow-counter one and N_SPLIT=1.
module tb_split_check_sequencer;

  localparam int VW = 400;
  localparam int TW = 8;

  typedef struct {
    logic       sat;
    logic [1:0] fail;
    logic [7:0] tag;
    int         lat;
    int         bound;
  } exp_t;

  logic clk = 1'b0;
  logic rst;

  logic          cand_valid [3];
  logic          res_ready  [3];
  logic          split_x    [3];
  logic [VW-1:0] cand_vec   [3];
  logic [TW-1:0] cand_tag   [3];

  logic          cand_ready   [3];
  logic          res_valid    [3];
  logic          res_sat      [3];
  logic [1:0]    split_sel    [3];
  logic [1:0]    res_fail_idx [3];
  logic [VW-1:0] split_vec    [3];
  logic [TW-1:0] res_tag      [3];
  logic [15:0]   sat_cnt      [3];
  logic [15:0]   unsat_cnt    [3];

  logic a_ready, a_valid, a_sat;
  logic [1:0] a_sel, a_fail;
  logic [VW-1:0] a_vec;
  logic [TW-1:0] a_tag;
  logic [15:0] a_scnt, a_ucnt;

  logic b_ready, b_valid, b_sat;
  logic [1:0] b_sel, b_fail;
  logic [VW-1:0] b_vec;
  logic [TW-1:0] b_tag;
  logic [1:0] b_scnt, b_ucnt;

  logic c_ready, c_valid, c_sat;
  logic [0:0] c_sel, c_fail;
  logic [VW-1:0] c_vec;
  logic [TW-1:0] c_tag;
  logic [15:0] c_scnt, c_ucnt;

  logic [3:0]    pat        [3];
  int            since      [3];
  logic [1:0]    last_sel   [3];
  bit            acc_flag   [3];
  int            cyc        [3];
  bit            busy       [3];
  bit            seen_valid [3];
  bit            hs_pending [3];
  logic [VW-1:0] exp_vec    [3];
  int            exp_sat    [3];
  int            exp_unsat  [3];
  exp_t          sbq [$];
  bit            mon_en = 1'b0;
  int            n_tests = 0;
  int            n_fail = 0;

  always #5 clk = ~clk;

  split_check_sequencer #(.VEC_W(VW), .N_SPLIT(4), .EVAL_LAT(1), .TAG_W(TW), .CNT_W(16)) dut_a (
    .clk(clk), .rst(rst), .cand_valid(cand_valid[0]), .cand_ready(a_ready),
    .cand_vec(cand_vec[0]), .cand_tag(cand_tag[0]), .split_sel(a_sel), .split_vec(a_vec),
    .split_x(split_x[0]), .res_valid(a_valid), .res_ready(res_ready[0]), .res_sat(a_sat),
    .res_fail_idx(a_fail), .res_tag(a_tag), .sat_cnt(a_scnt), .unsat_cnt(a_ucnt)
  );

  split_check_sequencer #(.VEC_W(VW), .N_SPLIT(4), .EVAL_LAT(3), .TAG_W(TW), .CNT_W(2)) dut_b (
    .clk(clk), .rst(rst), .cand_valid(cand_valid[1]), .cand_ready(b_ready),
    .cand_vec(cand_vec[1]), .cand_tag(cand_tag[1]), .split_sel(b_sel), .split_vec(b_vec),
    .split_x(split_x[1]), .res_valid(b_valid), .res_ready(res_ready[1]), .res_sat(b_sat),
    .res_fail_idx(b_fail), .res_tag(b_tag), .sat_cnt(b_scnt), .unsat_cnt(b_ucnt)
  );

  split_check_sequencer #(.VEC_W(VW), .N_SPLIT(1), .EVAL_LAT(2), .TAG_W(TW), .CNT_W(16)) dut_c (
    .clk(clk), .rst(rst), .cand_valid(cand_valid[2]), .cand_ready(c_ready),
    .cand_vec(cand_vec[2]), .cand_tag(cand_tag[2]), .split_sel(c_sel), .split_vec(c_vec),
    .split_x(split_x[2]), .res_valid(c_valid), .res_ready(res_ready[2]), .res_sat(c_sat),
    .res_fail_idx(c_fail), .res_tag(c_tag), .sat_cnt(c_scnt), .unsat_cnt(c_ucnt)
  );

  // Gather the three instances into uniform arrays for the model.
  always_comb begin
    cand_ready[0] = a_ready; res_valid[0] = a_valid; res_sat[0] = a_sat;
    split_sel[0] = a_sel; res_fail_idx[0] = a_fail; split_vec[0] = a_vec;
    res_tag[0] = a_tag; sat_cnt[0] = a_scnt; unsat_cnt[0] = a_ucnt;
    cand_ready[1] = b_ready; res_valid[1] = b_valid; res_sat[1] = b_sat;
    split_sel[1] = b_sel; res_fail_idx[1] = b_fail; split_vec[1] = b_vec;
    res_tag[1] = b_tag; sat_cnt[1] = {14'b0, b_scnt}; unsat_cnt[1] = {14'b0, b_ucnt};
    cand_ready[2] = c_ready; res_valid[2] = c_valid; res_sat[2] = c_sat;
    split_sel[2] = {1'b0, c_sel}; res_fail_idx[2] = {1'b0, c_fail}; split_vec[2] = c_vec;
    res_tag[2] = c_tag; sat_cnt[2] = c_scnt; unsat_cnt[2] = c_ucnt;
  end

  function automatic int lat_of(input int d);
    case (d)
      0: return 1;
      1: return 3;
      default: return 2;
    endcase
  endfunction

  function automatic int nsp_of(input int d);
    return (d == 2) ? 1 : 4;
  endfunction

  function automatic int cmax_of(input int d);
    return (d == 1) ? 3 : 65535;
  endfunction

  function automatic exp_t predict(input int d, input logic [3:0] p, input logic [7:0] tag);
    exp_t e;
    bit   found;
    found = 1'b0;
    e.tag = tag;
    e.sat = 1'b1;
    e.fail = 2'd0;
    e.lat = nsp_of(d) * (lat_of(d) + 1);
    e.bound = nsp_of(d) - 1;
    for (int i = 0; i < nsp_of(d); i++) begin
      if (!found && !p[i]) begin
        found = 1'b1;
        e.sat = 1'b0;
        e.fail = 2'(i);
        e.lat = (i + 1) * (lat_of(d) + 1);
        e.bound = i;
      end
    end
    return e;
  endfunction

  function automatic logic [VW-1:0] rand_vec();
    logic [VW-1:0] v;
    v = '0;
    for (int i = 0; i < 13; i++) v = {v[VW-33:0], 32'($urandom())};
    return v;
  endfunction

  task automatic checkOutput(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic timeoutFail(input string tag);
    n_tests++;
    n_fail++;
    $error("[TB] FAIL %s: wait bound expired", tag);
  endtask

  // Accept tracking and scoreboard push at each clock edge.
  always @(posedge clk) begin
    for (int d = 0; d < 3; d++) begin
      acc_flag[d] = 1'b0;
      if (rst) begin
        busy[d] = 1'b0;
        hs_pending[d] = 1'b0;
        exp_sat[d] = 0;
        exp_unsat[d] = 0;
      end else if (cand_valid[d] && cand_ready[d]) begin
        acc_flag[d] = 1'b1;
        busy[d] = 1'b1;
        seen_valid[d] = 1'b0;
        cyc[d] = 0;
        exp_vec[d] = cand_vec[d];
        sbq.push_back(predict(d, pat[d], cand_tag[d]));
      end else if (busy[d]) begin
        cyc[d]++;
      end
    end
    if (rst) sbq.delete();
  end

  // Checker emulation (garbage until EVAL_LAT cycles after a select change)
  // and result checking away from the active edge.
  always @(negedge clk) begin
    for (int d = 0; d < 3; d++) begin
      exp_t f;
      if (acc_flag[d] || (split_sel[d] != last_sel[d])) since[d] = 0;
      else if (since[d] < 1000) since[d]++;
      last_sel[d] = split_sel[d];
      split_x[d] = (since[d] >= lat_of(d)) ? pat[d][split_sel[d]] : ~pat[d][split_sel[d]];
      if (mon_en) begin
        if (hs_pending[d]) begin
          hs_pending[d] = 1'b0;
          checkOutput("sat_cnt", VW'(sat_cnt[d]), VW'(exp_sat[d]));
          checkOutput("unsat_cnt", VW'(unsat_cnt[d]), VW'(exp_unsat[d]));
        end
        if (busy[d]) begin
          checkOutput("split_vec_hold", split_vec[d], exp_vec[d]);
          if (sbq.size() == 0) begin
            timeoutFail("scoreboard_empty");
            busy[d] = 1'b0;
          end else begin
            f = sbq[0];
            checkOutput("split_sel_range", VW'(int'(split_sel[d]) <= f.bound), VW'(1));
            if (res_valid[d] && !seen_valid[d]) begin
              seen_valid[d] = 1'b1;
              checkOutput("latency", VW'(cyc[d]), VW'(f.lat));
            end
            if (res_valid[d] && res_ready[d]) begin
              void'(sbq.pop_front());
              checkOutput("res_sat", VW'(res_sat[d]), VW'(f.sat));
              checkOutput("res_fail_idx", VW'(res_fail_idx[d]), VW'(f.fail));
              checkOutput("res_tag", VW'(res_tag[d]), VW'(f.tag));
              if (f.sat) exp_sat[d] = (exp_sat[d] < cmax_of(d)) ? exp_sat[d] + 1 : exp_sat[d];
              else exp_unsat[d] = (exp_unsat[d] < cmax_of(d)) ? exp_unsat[d] + 1 : exp_unsat[d];
              hs_pending[d] = 1'b1;
              busy[d] = 1'b0;
            end else if (cyc[d] > 300) begin
              timeoutFail("result_timeout");
              busy[d] = 1'b0;
            end
          end
        end else begin
          checkOutput("no_spurious_res", VW'(res_valid[d]), VW'(0));
        end
      end
    end
  end

  task automatic applyStimulus(input int d, input logic [VW-1:0] v, input logic [7:0] tag, input logic [3:0] p);
    int n;
    pat[d] = p;
    cand_vec[d] = v;
    cand_tag[d] = tag;
    cand_valid[d] = 1'b1;
    n = 0;
    while (!cand_ready[d] && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) timeoutFail("accept_timeout");
    @(posedge clk);
    #1 cand_valid[d] = 1'b0;
  endtask

  task automatic waitResult(input int d);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((busy[d] || hs_pending[d]) && n < 500);
    if (n >= 500) timeoutFail("wait_result_timeout");
  endtask

  initial begin
    logic [VW-1:0] v;
    int n;
    rst = 1'b1;
    for (int d = 0; d < 3; d++) begin
      cand_valid[d] = 1'b0;
      res_ready[d] = 1'b1;
      cand_vec[d] = '0;
      cand_tag[d] = '0;
      pat[d] = 4'hF;
      since[d] = 0;
      last_sel[d] = 2'd0;
      busy[d] = 1'b0;
      hs_pending[d] = 1'b0;
      exp_sat[d] = 0;
      exp_unsat[d] = 0;
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      checkOutput("rst_cand_ready", VW'(cand_ready[d]), VW'(1));
      checkOutput("rst_res_valid", VW'(res_valid[d]), VW'(0));
      checkOutput("rst_split_sel", VW'(split_sel[d]), VW'(0));
      checkOutput("rst_split_vec", split_vec[d], VW'(0));
      checkOutput("rst_res_sat", VW'(res_sat[d]), VW'(0));
      checkOutput("rst_res_fail_idx", VW'(res_fail_idx[d]), VW'(0));
      checkOutput("rst_res_tag", VW'(res_tag[d]), VW'(0));
      checkOutput("rst_sat_cnt", VW'(sat_cnt[d]), VW'(0));
      checkOutput("rst_unsat_cnt", VW'(unsat_cnt[d]), VW'(0));
    end
    mon_en = 1'b1;

    $display("[TB] reset during WAIT of split 1");
    applyStimulus(0, rand_vec(), 8'h11, 4'hF);
    repeat (3) @(negedge clk);
    checkOutput("t5_in_split1", VW'(split_sel[0]), VW'(1));
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checkOutput("t5_cand_ready", VW'(cand_ready[0]), VW'(1));
    checkOutput("t5_res_valid", VW'(res_valid[0]), VW'(0));
    checkOutput("t5_split_sel", VW'(split_sel[0]), VW'(0));
    checkOutput("t5_split_vec", split_vec[0], VW'(0));
    checkOutput("t5_sat_cnt", VW'(sat_cnt[0]), VW'(0));
    checkOutput("t5_unsat_cnt", VW'(unsat_cnt[0]), VW'(0));
    applyStimulus(0, rand_vec(), 8'h22, 4'hF);
    waitResult(0);

    $display("[TB] full SAT and early UNSAT, EVAL_LAT=1");
    applyStimulus(0, rand_vec(), 8'hA5, 4'hF);
    waitResult(0);
    applyStimulus(0, rand_vec(), 8'h3C, 4'b1011);
    waitResult(0);

    $display("[TB] backpressure in RESP with next candidate waiting");
    res_ready[0] = 1'b0;
    applyStimulus(0, rand_vec(), 8'h7E, 4'b1110);
    n = 0;
    while (!res_valid[0] && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) timeoutFail("t3_res_valid_timeout");
    v = rand_vec();
    pat[0] = 4'hF;
    cand_vec[0] = v;
    cand_tag[0] = 8'h9D;
    cand_valid[0] = 1'b1;
    for (int i = 0; i < 10; i++) begin
      checkOutput("t3_res_valid", VW'(res_valid[0]), VW'(1));
      checkOutput("t3_cand_ready", VW'(cand_ready[0]), VW'(0));
      checkOutput("t3_res_sat", VW'(res_sat[0]), VW'(0));
      checkOutput("t3_res_fail_idx", VW'(res_fail_idx[0]), VW'(0));
      checkOutput("t3_res_tag", VW'(res_tag[0]), VW'(8'h7E));
      checkOutput("t3_sat_hold", VW'(sat_cnt[0]), VW'(exp_sat[0]));
      checkOutput("t3_unsat_hold", VW'(unsat_cnt[0]), VW'(exp_unsat[0]));
      @(negedge clk);
    end
    @(posedge clk);
    #1 res_ready[0] = 1'b1;
    @(negedge clk);
    checkOutput("t3_ready_before_hs", VW'(cand_ready[0]), VW'(0));
    @(negedge clk);
    checkOutput("t3_idle_ready", VW'(cand_ready[0]), VW'(1));
    checkOutput("t3_idle_valid", VW'(res_valid[0]), VW'(0));
    @(negedge clk);
    checkOutput("t3_accepted", VW'(cand_ready[0]), VW'(0));
    checkOutput("t3_new_vec", split_vec[0], v);
    cand_valid[0] = 1'b0;
    waitResult(0);

    $display("[TB] EVAL_LAT=3 with split_x wrong outside CHECK");
    applyStimulus(1, rand_vec(), 8'h41, 4'hF);
    waitResult(1);
    applyStimulus(1, rand_vec(), 8'h42, 4'b1011);
    waitResult(1);

    $display("[TB] counter saturation");
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, rand_vec(), 8'(8'h50 + i), 4'hF);
      waitResult(1);
    end
    checkOutput("t6_sat_saturated", VW'(sat_cnt[1]), VW'(3));
    checkOutput("t6_unsat_one", VW'(unsat_cnt[1]), VW'(1));

    $display("[TB] N_SPLIT=1");
    applyStimulus(2, rand_vec(), 8'hC1, 4'b0001);
    waitResult(2);
    applyStimulus(2, rand_vec(), 8'hC2, 4'b0000);
    waitResult(2);
    checkOutput("t6_n1_sat_cnt", VW'(sat_cnt[2]), VW'(1));
    checkOutput("t6_n1_unsat_cnt", VW'(unsat_cnt[2]), VW'(1));

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
